cordic_phase_sequencer: RTL and testbench

//  Initiator/consumer side of the iterative CORDIC strobe interface (x/y/z in, valid strobe; x/y/z out, valid strobe).

---
 rtl/cordic_phase_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_cordic_phase_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_sequencer.sv
// NCO front end for an iterative CORDIC core: folds an accumulated phase into the
// core's convergence range, issues one rotation per sample and unfolds the result.
module cordic_phase_sequencer #(
  parameter int N_FRAC  = 7,
  parameter int X_INIT  = 78,
  parameter int TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic [N_FRAC:0] phase_step_i,
  output logic [N_FRAC:0] cordic_x_o,
  output logic [N_FRAC:0] cordic_y_o,
  output logic [N_FRAC:0] cordic_z_o,
  output logic            cordic_valid_o,
  input  logic [N_FRAC:0] cordic_x_i,
  input  logic [N_FRAC:0] cordic_y_i,
  input  logic            cordic_valid_i,
  output logic [N_FRAC:0] cos_o,
  output logic [N_FRAC:0] sin_o,
  output logic            sample_valid_o,
  output logic            busy_o,
  output logic            timeout_o
);

  localparam int W  = N_FRAC + 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [W-1:0]  X_SEED   = W'(X_INIT);
  localparam logic [W-1:0]  ZERO_W   = {W{1'b0}};
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Phase outside [-0.5,+0.5) lies beyond the core's convergence range.
  function automatic logic needs_fold(input logic [W-1:0] p);
    return p[W-1] ^ p[W-2];
  endfunction

  function automatic logic [W-1:0] fold_angle(input logic [W-1:0] p);
    logic [W-1:0] r;
    if (needs_fold(p)) begin
      r = {~p[W-1], p[W-2:0]};
    end else begin
      r = p;
    end
    return r;
  endfunction

  // Two's complement negate with the most negative code clamped to max positive.
  function automatic logic [W-1:0] neg_sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    if (v == {1'b1, {(W-1){1'b0}}}) begin
      r = {1'b0, {(W-1){1'b1}}};
    end else begin
      r = (~v) + {{(W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [W-1:0]  phase_q, phase_d;
  logic          fold_q, fold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  cordic_x_q, cordic_x_d;
  logic [W-1:0]  cordic_y_q, cordic_y_d;
  logic [W-1:0]  cordic_z_q, cordic_z_d;
  logic          cordic_valid_q, cordic_valid_d;
  logic [W-1:0]  cos_q, cos_d;
  logic [W-1:0]  sin_q, sin_d;
  logic          sample_valid_q, sample_valid_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cordic_valid_i || (cnt_q == LAST_CNT)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; capture takes priority over timeout.
  always_comb begin
    phase_d        = phase_q;
    fold_d         = fold_q;
    cnt_d          = cnt_q;
    cordic_x_d     = cordic_x_q;
    cordic_y_d     = cordic_y_q;
    cordic_z_d     = cordic_z_q;
    cordic_valid_d = 1'b0;
    cos_d          = cos_q;
    sin_d          = sin_q;
    sample_valid_d = 1'b0;
    timeout_d      = timeout_q;
    busy_d         = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          cordic_x_d     = X_SEED;
          cordic_y_d     = ZERO_W;
          cordic_z_d     = fold_angle(phase_q);
          fold_d         = needs_fold(phase_q);
          cordic_valid_d = 1'b1;
        end else begin
          cordic_valid_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        cnt_d = ZERO_CNT;
      end
      ST_WAIT: begin
        if (cordic_valid_i) begin
          cos_d          = fold_q ? neg_sat(cordic_x_i) : cordic_x_i;
          sin_d          = fold_q ? neg_sat(cordic_y_i) : cordic_y_i;
          sample_valid_d = 1'b1;
          phase_d        = phase_q + phase_step_i;
        end else if (cnt_q == LAST_CNT) begin
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_CNT;
        end
      end
      default: begin
        cordic_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q        <= ZERO_W;
      fold_q         <= 1'b0;
      cnt_q          <= ZERO_CNT;
      cordic_x_q     <= ZERO_W;
      cordic_y_q     <= ZERO_W;
      cordic_z_q     <= ZERO_W;
      cordic_valid_q <= 1'b0;
      cos_q          <= ZERO_W;
      sin_q          <= ZERO_W;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      fold_q         <= fold_d;
      cnt_q          <= cnt_d;
      cordic_x_q     <= cordic_x_d;
      cordic_y_q     <= cordic_y_d;
      cordic_z_q     <= cordic_z_d;
      cordic_valid_q <= cordic_valid_d;
      cos_q          <= cos_d;
      sin_q          <= sin_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      timeout_q      <= timeout_d;
    end
  end

  assign cordic_x_o     = cordic_x_q;
  assign cordic_y_o     = cordic_y_q;
  assign cordic_z_o     = cordic_z_q;
  assign cordic_valid_o = cordic_valid_q;
  assign cos_o          = cos_q;
  assign sin_o          = sin_q;
  assign sample_valid_o = sample_valid_q;
  assign busy_o         = busy_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Directed bench for cordic_phase_sequencer; the core is modelled by driving
// result strobes from the scenario tasks at chosen latencies.
module tb_cordic_phase_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic [7:0] phase_step_i;
  logic [7:0] cordic_x_o, cordic_y_o, cordic_z_o;
  logic       cordic_valid_o;
  logic [7:0] cordic_x_i, cordic_y_i;
  logic       cordic_valid_i;
  logic [7:0] cos_o, sin_o;
  logic       sample_valid_o, busy_o, timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  cordic_phase_sequencer #(.N_FRAC(7), .X_INIT(78), .TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .phase_step_i(phase_step_i),
    .cordic_x_o(cordic_x_o), .cordic_y_o(cordic_y_o), .cordic_z_o(cordic_z_o),
    .cordic_valid_o(cordic_valid_o), .cordic_x_i(cordic_x_i), .cordic_y_i(cordic_y_i),
    .cordic_valid_i(cordic_valid_i), .cos_o(cos_o), .sin_o(sin_o),
    .sample_valid_o(sample_valid_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One request with enable pulsed, reply after lat extra WAIT cycles.
  task automatic issue_and_reply(input logic [7:0] rx, input logic [7:0] ry, input int lat,
                                 output logic req, output logic [7:0] x_seen, output logic [7:0] z_seen,
                                 output logic sv, output logic [7:0] c, output logic [7:0] s);
    enable_i = 1'b1;
    tick();
    req = cordic_valid_o; x_seen = cordic_x_o; z_seen = cordic_z_o;
    enable_i = 1'b0;
    tick();
    repeat (lat) tick();
    cordic_x_i = rx; cordic_y_i = ry; cordic_valid_i = 1'b1;
    tick();
    cordic_valid_i = 1'b0;
    sv = sample_valid_o; c = cos_o; s = sin_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b0; phase_step_i = 8'd0;
    cordic_x_i = 8'd0; cordic_y_i = 8'd0; cordic_valid_i = 1'b0;
    repeat (2) tick();
    n_cmp++; if (cordic_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %0d expected 0", cordic_valid_o); end
    n_cmp++; if (cordic_x_o !== 8'd0) begin n_bad++; $display("FAIL rst_x: got %0d expected 0", cordic_x_o); end
    n_cmp++; if ({cos_o, sin_o} !== 16'd0) begin n_bad++; $display("FAIL rst_cos_sin: got %h expected 0000", {cos_o, sin_o}); end
    n_cmp++; if ({busy_o, timeout_o, sample_valid_o} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b expected 000", {busy_o, timeout_o, sample_valid_o}); end
    rst_i = 1'b0;
    tick();
    n_cmp++; if ({cordic_valid_o, busy_o} !== 2'b00) begin n_bad++; $display("FAIL rst_idle: got %b expected 00", {cordic_valid_o, busy_o}); end
  endtask

  task automatic test_single();
    enable_i = 1'b1; phase_step_i = 8'd0;
    tick();
    n_cmp++; if (cordic_valid_o !== 1'b1) begin n_bad++; $display("FAIL t1_req: got %0d expected 1", cordic_valid_o); end
    n_cmp++; if (cordic_x_o !== 8'd78) begin n_bad++; $display("FAIL t1_x: got %0d expected 78", cordic_x_o); end
    n_cmp++; if ({cordic_y_o, cordic_z_o} !== 16'd0) begin n_bad++; $display("FAIL t1_yz: got %h expected 0000", {cordic_y_o, cordic_z_o}); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL t1_busy_issue: got %0d expected 1", busy_o); end
    enable_i = 1'b0;
    tick();
    n_cmp++; if ({cordic_valid_o, busy_o} !== 2'b01) begin n_bad++; $display("FAIL t1_wait: got %b expected 01", {cordic_valid_o, busy_o}); end
    cordic_x_i = 8'd127; cordic_y_i = 8'd0; cordic_valid_i = 1'b1;
    tick();
    cordic_valid_i = 1'b0;
    n_cmp++; if (sample_valid_o !== 1'b1) begin n_bad++; $display("FAIL t1_sv: got %0d expected 1", sample_valid_o); end
    n_cmp++; if ({cos_o, sin_o} !== {8'd127, 8'd0}) begin n_bad++; $display("FAIL t1_cos_sin: got %h expected 7f00", {cos_o, sin_o}); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL t1_busy_done: got %0d expected 0", busy_o); end
    tick();
    n_cmp++; if ({sample_valid_o, cordic_valid_o} !== 2'b00) begin n_bad++; $display("FAIL t1_pulse_end: got %b expected 00", {sample_valid_o, cordic_valid_o}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_z   [4] = '{8'h00, 8'hC0, 8'h00, 8'hC0};
    logic [7:0] exp_cos [4] = '{8'd10, 8'hF6, 8'hF6, 8'd10};
    logic [7:0] exp_sin [4] = '{8'd20, 8'hEC, 8'hEC, 8'd20};
    phase_step_i = 8'd64; enable_i = 1'b1; cordic_x_i = 8'd10; cordic_y_i = 8'd20;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if ({cordic_valid_o, cordic_z_o} !== {1'b1, exp_z[k]}) begin n_bad++; $display("FAIL t2_req_z[%0d]: got %b/%0d expected 1/%0d", k, cordic_valid_o, $signed(cordic_z_o), $signed(exp_z[k])); end
      tick();
      n_cmp++; if (cordic_valid_o !== 1'b0) begin n_bad++; $display("FAIL t2_req_drop[%0d]: got %0d expected 0", k, cordic_valid_o); end
      cordic_valid_i = 1'b1;
      tick();
      cordic_valid_i = 1'b0;
      if (k == 3) enable_i = 1'b0;
      n_cmp++; if ({sample_valid_o, cos_o, sin_o} !== {1'b1, exp_cos[k], exp_sin[k]}) begin n_bad++; $display("FAIL t2_sample[%0d]: got %b/%0d/%0d expected 1/%0d/%0d", k, sample_valid_o, $signed(cos_o), $signed(sin_o), $signed(exp_cos[k]), $signed(exp_sin[k])); end
    end
    tick();
    n_cmp++; if ({cordic_valid_o, busy_o, sample_valid_o} !== 3'b000) begin n_bad++; $display("FAIL t2_stop: got %b expected 000", {cordic_valid_o, busy_o, sample_valid_o}); end
  endtask

  task automatic test_unfold();
    logic req, sv; logic [7:0] xs, zs, c, s;
    phase_step_i = 8'd96;
    issue_and_reply(8'd0, 8'd0, 1, req, xs, zs, sv, c, s);
    n_cmp++; if (zs !== 8'h00) begin n_bad++; $display("FAIL t3_z0: got %0d expected 0", $signed(zs)); end
    phase_step_i = 8'd0;
    issue_and_reply(8'd50, 8'hC4, 2, req, xs, zs, sv, c, s);
    n_cmp++; if (zs !== 8'hE0) begin n_bad++; $display("FAIL t3_z96: got %0d expected -32", $signed(zs)); end
    n_cmp++; if ({sv, c, s} !== {1'b1, 8'hCE, 8'h3C}) begin n_bad++; $display("FAIL t3_unfold: got %b/%0d/%0d expected 1/-50/60", sv, $signed(c), $signed(s)); end
    issue_and_reply(8'h80, 8'h80, 0, req, xs, zs, sv, c, s);
    n_cmp++; if ({c, s} !== {8'h7F, 8'h7F}) begin n_bad++; $display("FAIL t3_saturate: got %0d/%0d expected 127/127", $signed(c), $signed(s)); end
  endtask

  task automatic test_timeout();
    logic req, sv, sv_seen; logic [7:0] xs, zs, c, s;
    issue_and_reply(8'd30, 8'd40, 14, req, xs, zs, sv, c, s);
    n_cmp++; if ({sv, c, s} !== {1'b1, 8'hE2, 8'hD8}) begin n_bad++; $display("FAIL t4_last_cycle: got %b/%0d/%0d expected 1/-30/-40", sv, $signed(c), $signed(s)); end
    n_cmp++; if (timeout_o !== 1'b0) begin n_bad++; $display("FAIL t4_no_timeout: got %0d expected 0", timeout_o); end
    phase_step_i = 8'd5; enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
    tick();
    sv_seen = 1'b0;
    repeat (14) begin tick(); sv_seen = sv_seen | sample_valid_o; end
    n_cmp++; if ({busy_o, timeout_o} !== 2'b10) begin n_bad++; $display("FAIL t4_still_wait: got %b expected 10", {busy_o, timeout_o}); end
    tick();
    sv_seen = sv_seen | sample_valid_o;
    n_cmp++; if ({timeout_o, busy_o, sv_seen} !== 3'b100) begin n_bad++; $display("FAIL t4_timeout: got %b expected 100", {timeout_o, busy_o, sv_seen}); end
    phase_step_i = 8'd0;
    issue_and_reply(8'd1, 8'd2, 0, req, xs, zs, sv, c, s);
    n_cmp++; if (zs !== 8'hE0) begin n_bad++; $display("FAIL t4_phase_kept: got %0d expected -32", $signed(zs)); end
    n_cmp++; if ({c, s, timeout_o} !== {8'hFF, 8'hFE, 1'b1}) begin n_bad++; $display("FAIL t4_after: got %0d/%0d/%b expected -1/-2/1", $signed(c), $signed(s), timeout_o); end
  endtask

  task automatic test_spurious();
    cordic_x_i = 8'd99; cordic_y_i = 8'd99; cordic_valid_i = 1'b1;
    tick();
    n_cmp++; if ({sample_valid_o, busy_o, cos_o, sin_o} !== {2'b00, 8'hFF, 8'hFE}) begin n_bad++; $display("FAIL t5_idle: got %b/%h/%h expected 00/ff/fe", {sample_valid_o, busy_o}, cos_o, sin_o); end
    enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
    tick();
    cordic_valid_i = 1'b0;
    n_cmp++; if ({sample_valid_o, busy_o, cos_o} !== {2'b01, 8'hFF}) begin n_bad++; $display("FAIL t5_issue: got %b/%h expected 01/ff", {sample_valid_o, busy_o}, cos_o); end
    cordic_x_i = 8'd5; cordic_y_i = 8'd5; cordic_valid_i = 1'b1;
    tick();
    cordic_valid_i = 1'b0;
    n_cmp++; if ({sample_valid_o, cos_o, sin_o} !== {1'b1, 8'hFB, 8'hFB}) begin n_bad++; $display("FAIL t5_recover: got %b/%0d/%0d expected 1/-5/-5", sample_valid_o, $signed(cos_o), $signed(sin_o)); end
  endtask

  task automatic test_async_reset();
    logic req, sv; logic [7:0] xs, zs, c, s;
    enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b1;
    #1;
    n_cmp++; if ({cordic_valid_o, busy_o, timeout_o, sample_valid_o} !== 4'b0000) begin n_bad++; $display("FAIL t6_flags: got %b expected 0000", {cordic_valid_o, busy_o, timeout_o, sample_valid_o}); end
    n_cmp++; if ({cordic_x_o, cordic_z_o, cos_o, sin_o} !== 32'd0) begin n_bad++; $display("FAIL t6_data: got %h expected 0", {cordic_x_o, cordic_z_o, cos_o, sin_o}); end
    tick();
    rst_i = 1'b0;
    cordic_x_i = 8'd77; cordic_valid_i = 1'b1;
    tick();
    cordic_valid_i = 1'b0;
    n_cmp++; if ({sample_valid_o, busy_o, cos_o} !== {2'b00, 8'd0}) begin n_bad++; $display("FAIL t6_late_strobe: got %b/%h expected 00/00", {sample_valid_o, busy_o}, cos_o); end
    issue_and_reply(8'd127, 8'd0, 2, req, xs, zs, sv, c, s);
    n_cmp++; if ({req, xs, zs} !== {1'b1, 8'd78, 8'd0}) begin n_bad++; $display("FAIL t6_restart_req: got %b/%0d/%0d expected 1/78/0", req, xs, $signed(zs)); end
    n_cmp++; if ({sv, c, s} !== {1'b1, 8'd127, 8'd0}) begin n_bad++; $display("FAIL t6_restart_sample: got %b/%0d/%0d expected 1/127/0", sv, $signed(c), $signed(s)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_unfold();
    test_timeout();
    test_spurious();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
